// File: rtl/slave_fifo_stream_out.sv
// FX3 slave-FIFO stream-OUT reader: drains the consumer socket and realigns read data to the FX3 read latency.
// Optional sequence checker is compiled in when STREAM_OUT_CHECK_EN is defined.
module slave_fifo_stream_out #(
  parameter int RD_LATENCY = 2,
  parameter int RD_DRAIN   = 2
) (
  input  logic        clk_100,
  input  logic        reset_,
  input  logic        stream_out_mode_selected,
  input  logic        flagc_d,
  input  logic        flagd_d,
  input  logic [31:0] data_in_stream_out,
  output logic        slrd_streamOUT_,
  output logic        sloe_streamOUT_,
  output logic [31:0] data_out_stream_out,
  output logic        data_valid_out,
  output logic [31:0] word_count,
  output logic        check_error,
  output logic [15:0] error_count
);

  localparam int DW = (RD_DRAIN > 1) ? $clog2(RD_DRAIN) : 1;
  localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FLAGC_RCVD,
    WAIT_FLAGD,
    READ,
    RD_OE_DELAY,
    OE_DELAY
  } state_t;

  state_t                  state;
  logic [DW-1:0]           drain_cnt;
  logic [LW-1:0]           lat_cnt;
  logic [RD_LATENCY-1:0]   rd_pipe;
  logic                    capture;

  // SLRD#/SLOE# are registered alongside the state so they always equal its decode.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state           <= IDLE;
      slrd_streamOUT_ <= 1'b1;
      sloe_streamOUT_ <= 1'b1;
      drain_cnt       <= '0;
      lat_cnt         <= '0;
    end else if (!stream_out_mode_selected) begin
      state           <= IDLE;
      slrd_streamOUT_ <= 1'b1;
      sloe_streamOUT_ <= 1'b1;
      drain_cnt       <= '0;
      lat_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flagc_d) begin
            state <= FLAGC_RCVD;
          end
        end
        FLAGC_RCVD: begin
          state <= WAIT_FLAGD;
        end
        WAIT_FLAGD: begin
          if (flagd_d) begin
            state           <= READ;
            slrd_streamOUT_ <= 1'b0;
            sloe_streamOUT_ <= 1'b0;
          end
        end
        READ: begin
          if (!flagd_d) begin
            state     <= RD_OE_DELAY;
            drain_cnt <= DW'(RD_DRAIN - 1);
          end
        end
        RD_OE_DELAY: begin
          if (drain_cnt == '0) begin
            state           <= OE_DELAY;
            slrd_streamOUT_ <= 1'b1;
            lat_cnt         <= LW'(RD_LATENCY - 1);
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        OE_DELAY: begin
          if (lat_cnt == '0) begin
            state           <= IDLE;
            sloe_streamOUT_ <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: begin
          state           <= IDLE;
          slrd_streamOUT_ <= 1'b1;
          sloe_streamOUT_ <= 1'b1;
        end
      endcase
    end
  end

  // Tracks each issued SLRD# through the FX3 read latency; the last stage marks a live word on the bus.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      rd_pipe <= '0;
    end else if (!stream_out_mode_selected) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(!slrd_streamOUT_);
    end
  end

  assign capture = rd_pipe[RD_LATENCY-1] & ~sloe_streamOUT_;

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      data_out_stream_out <= '0;
      data_valid_out      <= 1'b0;
      word_count          <= '0;
    end else if (!stream_out_mode_selected) begin
      data_valid_out <= 1'b0;
      word_count     <= '0;
    end else begin
      data_valid_out <= capture;
      if (capture) begin
        data_out_stream_out <= data_in_stream_out;
        word_count          <= word_count + 32'd1;
      end
    end
  end

`ifdef STREAM_OUT_CHECK_EN
  logic [31:0] expected_word;

  // On a mismatch the expectation resyncs to the received word so a single skip counts once.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      expected_word <= '0;
      check_error   <= 1'b0;
      error_count   <= '0;
    end else if (!stream_out_mode_selected) begin
      expected_word <= '0;
      check_error   <= 1'b0;
      error_count   <= '0;
    end else if (capture) begin
      if (data_in_stream_out != expected_word) begin
        check_error   <= 1'b1;
        expected_word <= data_in_stream_out + 32'd1;
        if (error_count != 16'hFFFF) begin
          error_count <= error_count + 16'd1;
        end
      end else begin
        expected_word <= expected_word + 32'd1;
      end
    end
  end
`else
  assign check_error = 1'b0;
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_slave_fifo_stream_out.sv
// Scoreboard bench for slave_fifo_stream_out: an FX3 read-latency model feeds words and queues them for comparison.
module tb_slave_fifo_stream_out;

  localparam int LAT_A = 2;

  logic        clk_100 = 1'b0;
  logic        reset_;
  logic        mode, flagc, flagd;
  logic [31:0] data_in;
  logic        slrd_, sloe_, data_valid;
  logic [31:0] data_out, word_count;
  logic        check_error;
  logic [15:0] error_count;

  logic        mode_b, flagc_b, flagd_b;
  logic [31:0] data_in_b;
  logic        slrd_b_, sloe_b_, data_valid_b;
  logic [31:0] data_out_b, word_count_b;
  logic        check_error_b;
  logic [15:0] error_count_b;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];
  int          fx3_next = 0;
  bit          inject_skip = 0;
  logic [7:0]  hist = '0;
  int          slrd_low_cnt = 0, sloe_low_cnt = 0, strobe_cnt = 0;
  int          cyc = 0;
  int          b_first_low = -1, b_slrd_low = 0, b_sloe_low = 0;
  int          b_strobe_cyc[$];
  logic [31:0] b_strobe_data[$];
  int          waited;
  logic [31:0] exp_err;

  always #5 clk_100 = ~clk_100;

  slave_fifo_stream_out #(.RD_LATENCY(LAT_A), .RD_DRAIN(2)) dut (
    .clk_100(clk_100), .reset_(reset_), .stream_out_mode_selected(mode),
    .flagc_d(flagc), .flagd_d(flagd), .data_in_stream_out(data_in),
    .slrd_streamOUT_(slrd_), .sloe_streamOUT_(sloe_),
    .data_out_stream_out(data_out), .data_valid_out(data_valid),
    .word_count(word_count), .check_error(check_error), .error_count(error_count)
  );

  slave_fifo_stream_out #(.RD_LATENCY(3), .RD_DRAIN(1)) dut_b (
    .clk_100(clk_100), .reset_(reset_), .stream_out_mode_selected(mode_b),
    .flagc_d(flagc_b), .flagd_d(flagd_b), .data_in_stream_out(data_in_b),
    .slrd_streamOUT_(slrd_b_), .sloe_streamOUT_(sloe_b_),
    .data_out_stream_out(data_out_b), .data_valid_out(data_valid_b),
    .word_count(word_count_b), .check_error(check_error_b), .error_count(error_count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic fc, input logic fd);
    mode  = m;
    flagc = fc;
    flagd = fd;
  endtask

  task automatic waitForSlrdLow(input string tag, input int budget, output int n);
    n = 0;
    while (slrd_ !== 1'b0 && n < budget) begin
      @(negedge clk_100);
      n++;
    end
    if (slrd_ !== 1'b0) checkOutput({tag, "_timeout"}, {31'd0, slrd_}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_slrd"}, {31'd0, slrd_}, 32'd1);
    checkOutput({tag, "_sloe"}, {31'd0, sloe_}, 32'd1);
    checkOutput({tag, "_data_out"}, data_out, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
    checkOutput({tag, "_word_count"}, word_count, 32'd0);
    checkOutput({tag, "_check_error"}, {31'd0, check_error}, 32'd0);
    checkOutput({tag, "_error_count"}, {16'd0, error_count}, 32'd0);
  endtask

  task automatic clearCounters();
    slrd_low_cnt = 0;
    sloe_low_cnt = 0;
    strobe_cnt   = 0;
  endtask

  // FX3 model: a read issued in cycle c puts its word on the bus in cycle c+LAT_A; the scoreboard checks every strobe.
  initial begin
    forever begin
      @(negedge clk_100);
      cyc++;
      if (!reset_) begin
        hist     = '0;
        fx3_next = 0;
        exp_q.delete();
      end else begin
        if (!slrd_) slrd_low_cnt++;
        if (!sloe_) sloe_low_cnt++;
        if (data_valid) begin
          strobe_cnt++;
          checkOutput("sb_queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) checkOutput("sb_data", data_out, exp_q.pop_front());
        end
        hist = {hist[6:0], ~slrd_};
        if (hist[LAT_A]) begin
          data_in = (inject_skip && fx3_next == 3) ? 32'd5 : 32'(fx3_next);
          exp_q.push_back(data_in);
          fx3_next = int'(data_in) + 1;
        end else begin
          data_in = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
      end
      if (!slrd_b_) b_slrd_low++;
      if (!sloe_b_) b_sloe_low++;
      if (!slrd_b_ && b_first_low < 0) b_first_low = cyc;
      if (data_valid_b) begin
        b_strobe_cyc.push_back(cyc);
        b_strobe_data.push_back(data_out_b);
      end
      data_in_b = 32'(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef STREAM_OUT_CHECK_EN
    exp_err = 32'd1;
`else
    exp_err = 32'd0;
`endif
    reset_ = 1'b0;
    applyStimulus(0, 0, 0);
    data_in = '0;
    mode_b = 0; flagc_b = 0; flagd_b = 0; data_in_b = '0;
    repeat (2) @(negedge clk_100);
    checkResetValues("por");
    reset_ = 1'b1;

    $display("[TB] burst of 10 READ cycles plus drain");
    @(negedge clk_100);
    clearCounters();
    applyStimulus(1, 1, 1);
    waitForSlrdLow("burst1", 20, waited);
    checkOutput("burst1_start_latency", 32'(waited), 32'd3);
    repeat (9) @(negedge clk_100);
    applyStimulus(1, 0, 0);
    repeat (15) @(negedge clk_100);
    checkOutput("burst1_slrd_low", 32'(slrd_low_cnt), 32'd12);
    checkOutput("burst1_sloe_low", 32'(sloe_low_cnt), 32'd14);
    checkOutput("burst1_strobes", 32'(strobe_cnt), 32'd12);
    checkOutput("burst1_word_count", word_count, 32'd12);
    checkOutput("burst1_last_data", data_out, 32'd11);
    checkOutput("burst1_check_error", {31'd0, check_error}, 32'd0);
    checkOutput("burst1_sb_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk_100);
    checkOutput("deselect_word_count", word_count, 32'd0);

    $display("[TB] burst with a skipped sequence value");
    fx3_next = 0;
    inject_skip = 1;
    clearCounters();
    applyStimulus(1, 1, 1);
    waitForSlrdLow("burst2", 20, waited);
    repeat (9) @(negedge clk_100);
    applyStimulus(1, 0, 0);
    repeat (15) @(negedge clk_100);
    inject_skip = 0;
    checkOutput("burst2_strobes", 32'(strobe_cnt), 32'd12);
    checkOutput("burst2_word_count", word_count, 32'd12);
    checkOutput("burst2_last_data", data_out, 32'd13);
    checkOutput("burst2_check_error", {31'd0, check_error}, exp_err);
    checkOutput("burst2_error_count", {16'd0, error_count}, exp_err);
    applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk_100);
    checkOutput("deselect_check_error", {31'd0, check_error}, 32'd0);
    checkOutput("deselect_error_count", {16'd0, error_count}, 32'd0);

    $display("[TB] flagc high with flagd held low");
    fx3_next = 0;
    clearCounters();
    applyStimulus(1, 1, 0);
    repeat (20) @(negedge clk_100);
    checkOutput("park_slrd_low", 32'(slrd_low_cnt), 32'd0);
    checkOutput("park_sloe_low", 32'(sloe_low_cnt), 32'd0);
    checkOutput("park_strobes", 32'(strobe_cnt), 32'd0);

    $display("[TB] deselect during READ");
    applyStimulus(1, 1, 1);
    waitForSlrdLow("desel", 20, waited);
    checkOutput("desel_start_latency", 32'(waited), 32'd1);
    repeat (2) @(negedge clk_100);
    applyStimulus(0, 0, 0);
    @(negedge clk_100);
    checkOutput("desel_slrd", {31'd0, slrd_}, 32'd1);
    checkOutput("desel_sloe", {31'd0, sloe_}, 32'd1);
    checkOutput("desel_valid", {31'd0, data_valid}, 32'd0);
    checkOutput("desel_word_count", word_count, 32'd0);
    checkOutput("desel_data_hold", data_out, 32'd13);
    repeat (10) @(negedge clk_100);
    checkOutput("desel_late_strobes", 32'(strobe_cnt), 32'd0);
    exp_q.delete();
    fx3_next = 0;

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus(1, 1, 1);
    waitForSlrdLow("rst", 20, waited);
    repeat (5) @(negedge clk_100);
    checkOutput("rst_pre_strobes", {31'd0, strobe_cnt > 0}, 32'd1);
    #2 reset_ = 1'b0;
    #1 checkResetValues("async_rst");
    repeat (2) @(negedge clk_100);
    #2 reset_ = 1'b1;
    clearCounters();
    waitForSlrdLow("restart", 20, waited);
    checkOutput("restart_latency", 32'(waited), 32'd3);
    repeat (3) @(negedge clk_100);
    applyStimulus(1, 0, 0);
    repeat (15) @(negedge clk_100);
    checkOutput("restart_strobes", 32'(strobe_cnt), 32'd6);
    checkOutput("restart_word_count", word_count, 32'd6);
    checkOutput("restart_data_hold", data_out, 32'd5);
    checkOutput("restart_valid_idle", {31'd0, data_valid}, 32'd0);
    checkOutput("restart_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] latency 3, drain 1, single-cycle flagd pulse");
    mode_b = 1; flagc_b = 1; flagd_b = 0;
    repeat (4) @(negedge clk_100);
    flagd_b = 1;
    @(negedge clk_100);
    flagd_b = 0;
    flagc_b = 0;
    repeat (12) @(negedge clk_100);
    checkOutput("b_slrd_low", 32'(b_slrd_low), 32'd2);
    checkOutput("b_sloe_low", 32'(b_sloe_low), 32'd5);
    checkOutput("b_strobes", 32'(b_strobe_cyc.size()), 32'd2);
    checkOutput("b_word_count", word_count_b, 32'd2);
    if (b_strobe_cyc.size() >= 2) begin
      checkOutput("b_strobe0_cycle", 32'(b_strobe_cyc[0] - b_first_low), 32'd4);
      checkOutput("b_strobe1_cycle", 32'(b_strobe_cyc[1] - b_first_low), 32'd5);
      checkOutput("b_strobe0_data", b_strobe_data[0], 32'(b_first_low + 3));
      checkOutput("b_strobe1_data", b_strobe_data[1], 32'(b_first_low + 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slave_fifo_stream_out.md
# slave_fifo_stream_out

Stream-OUT reader for the FX3 synchronous slave FIFO (2-bit address) interface: drains host-to-device data from the FX3 consumer socket by driving SLOE#/SLRD#, realigns the read data against the fixed FX3 read latency, and presents words with a valid strobe. It is the receive-side counterpart of the stream-IN data generator. It sits beside that block in the FPGA top level, and its slave-FIFO controls are muxed onto the FX3 pins when stream-OUT mode is selected.

## Interface
- RD_LATENCY, 2: clocks from SLRD# sampled low by FX3 to the corresponding word on the data bus (range 1..4).
- RD_DRAIN, 2: clocks SLRD# stays low after flagd_d drops (watermark drain).
- clk_100  in  1  100 MHz interface clock; all logic on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- stream_out_mode_selected  in  1  enables the block; low forces idle.
- flagc_d  in  1  registered FX3 FLAGC; 1 = consumer socket has data.
- flagd_d  in  1  registered FX3 FLAGD (partial flag); 1 = more than watermark words remain.
- data_in_stream_out  in  32  FX3 data bus.
- slrd_streamOUT_  out  1  SLRD#, active low.
- sloe_streamOUT_  out  1  SLOE#, active low.
- data_out_stream_out  out  32  captured word.
- data_valid_out  out  1  one-cycle strobe per captured word.
- word_count  out  32  words captured since mode select.
- check_error  out  1  sticky sequence-error flag.
- error_count  out  16  number of mismatched words.

## Operation
- States: IDLE, FLAGC_RCVD, WAIT_FLAGD, READ, RD_OE_DELAY, OE_DELAY. The state register is async-reset to IDLE.
- IDLE -> FLAGC_RCVD when mode selected and flagc_d = 1.
- FLAGC_RCVD -> WAIT_FLAGD unconditionally. This gives one settle cycle.
- WAIT_FLAGD -> READ when flagd_d = 1; otherwise stay.
- READ -> RD_OE_DELAY when flagd_d = 0; otherwise stay.
- RD_OE_DELAY lasts exactly RD_DRAIN cycles, counted by a down-counter, then goes to OE_DELAY.
- OE_DELAY lasts exactly RD_LATENCY cycles, then goes to IDLE.
- slrd_streamOUT_ = 0 in READ and RD_OE_DELAY; otherwise 1.
- sloe_streamOUT_ = 0 in READ, RD_OE_DELAY and OE_DELAY; otherwise 1. Both are decoded from registered state.
- Read pipeline: a RD_LATENCY-deep shift register of ~slrd_streamOUT_. When its last stage is 1 and sloe_ is low:
  - data_out_stream_out <= data_in_stream_out;
  - data_valid_out <= 1;
  - word_count increments, modulo 2^32.
- data_out_stream_out holds its value between strobes.
- Mode deselected (any state):
  - next state is IDLE;
  - pipeline and drain/latency counters clear;
  - data_valid_out = 0;
  - word_count, check_error and error_count clear;
  - data_out_stream_out holds.
- Reset mid-transfer: all outputs take their reset values immediately (async), with no completion of in-flight reads.
- Reset values: slrd_ = 1, sloe_ = 1, data_out = 0, data_valid = 0, word_count = 0, check_error = 0, error_count = 0.

## Timing
- Edge k: state enters READ; slrd_/sloe_ go low in cycle k.
- The first data_valid_out is high in cycle k+RD_LATENCY+1, carrying the bus value sampled at that edge.
- With no stall there is one word per clock in READ and RD_OE_DELAY.
- Total words per burst = cycles in READ + RD_DRAIN.
- sloe_ stays low RD_LATENCY cycles past the last SLRD# low, so the final word is captured under SLOE#.
- flagc_d/flagd_d are already registered externally; the FSM adds no further synchronizer.
- A flagd_d drop in the first READ cycle still yields 1 + RD_DRAIN reads.
- If flagc_d is still high on return to IDLE, the next burst starts one cycle later.

## Configuration
- STREAM_OUT_CHECK_EN defined: a sequence checker is compiled in.
  - Expected value starts at 0 on mode select and increments per valid word, wrapping at 2^32.
  - On a mismatch, check_error sets (sticky until deselect/reset) and error_count increments, saturating at 16'hFFFF.
  - The expected value resyncs to received+1 after each mismatch, so one bad word counts once.
- Not defined: checker logic is absent; check_error and error_count are tied to 0. Ports remain present.

## Test plan
- Mode on, flagc_d = 1, flagd_d = 1 for 10 cycles then 0; FX3 model returns 0,1,2,… with RD_LATENCY = 2 -> slrd_ low 12 cycles, sloe_ low 14, exactly 12 valid strobes with data 0..11, word_count = 12, check_error = 0.
- Same burst, but the model injects 5 in place of 3 -> with STREAM_OUT_CHECK_EN: check_error = 1, error_count = 1, later words pass; without the macro: both remain 0.
- flagc_d = 1 but flagd_d held 0 for 20 cycles -> FSM parks in WAIT_FLAGD, slrd_ = 1, sloe_ = 1, no valid.
- Deselect mode during READ -> next cycle slrd_ = 1, sloe_ = 1, data_valid = 0, word_count = 0, and no late strobes from the pipeline.
- Assert reset_ low mid-burst, asynchronously to the clock -> all outputs at reset values before the next edge; after release with flags high, the burst restarts from IDLE.
- RD_LATENCY = 3, RD_DRAIN = 1, single-cycle flagd_d pulse -> 2 reads, valid strobes in cycles k+4 and k+5, sloe_ low 5 cycles.
